// File: rtl/dlfloat_pkg.sv
// Shared DLFloat16 definitions: word format constants, stream header layout
// and the result-streamer state encoding.
package dlfloat_pkg;

    localparam int DLF_W = 16;
    localparam logic [DLF_W-1:0] DLF_NAN  = 16'hFFFF;
    localparam logic [DLF_W-1:0] DLF_ZERO = 16'h0000;

    // Header byte layout: {mark, special, zero, sign, seq[3:0]}
    localparam int HDR_MARK_BIT    = 7;
    localparam int HDR_SPECIAL_BIT = 6;
    localparam int HDR_ZERO_BIT    = 5;
    localparam int HDR_SIGN_BIT    = 4;
    localparam int HDR_SEQ_LSB     = 0;
    localparam int HDR_SEQ_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        MSB  = 2'd2,
        LSB  = 2'd3
    } streamer_state_e;

    function automatic logic [7:0] dlf_header(input logic [DLF_W-1:0] v,
                                              input logic [HDR_SEQ_W-1:0] seq);
        logic [7:0] h;
        h = 8'h00;
        h[HDR_MARK_BIT]    = 1'b1;
        h[HDR_SPECIAL_BIT] = (v == DLF_NAN);
        h[HDR_ZERO_BIT]    = (v == DLF_ZERO);
        h[HDR_SIGN_BIT]    = v[DLF_W-1];
        h[HDR_SEQ_LSB +: HDR_SEQ_W] = seq;
        return h;
    endfunction

endpackage

// File: rtl/dlfloat_sync_fifo.sv
// Single-clock FIFO with registered occupancy; full/empty derive from the
// occupancy register only, so they carry no combinational input paths.
module dlfloat_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [4:0]       level
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [4:0]       level_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (level_r == 5'(DEPTH));
    assign empty     = (level_r == 5'd0);
    assign level     = level_r;
    assign rdata     = mem_r[rd_ptr_r];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            level_r  <= 5'd0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + 5'd1;
                2'b01:   level_r <= level_r - 5'd1;
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/dlfloat_result_streamer.sv
// Buffers DLFloat16 MAC results and serialises each into an optional header
// byte followed by the MSB and LSB bytes on a valid/ready byte stream.
module dlfloat_result_streamer
    import dlfloat_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DLF_W-1:0] res_data,
    input  logic             res_valid,
    output logic             res_ready,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    input  logic             frame_en,
    input  logic             clr_ovf,
    output logic             overflow,
    output logic [4:0]       level
);

    streamer_state_e  state_r, state_s;
    logic [DLF_W-1:0] hold_r, hold_s;
    logic [3:0]       seq_r, seq_s;
    logic [7:0]       tx_data_r, tx_data_s;
    logic             tx_valid_r, tx_valid_s;
    logic             overflow_r;
    logic             full_s, empty_s, pop_s, xfer_s, do_load_s;
    logic [DLF_W-1:0] fifo_rdata_s;

    dlfloat_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DLF_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (res_valid),
        .pop   (pop_s),
        .wdata (res_data),
        .rdata (fifo_rdata_s),
        .full  (full_s),
        .empty (empty_s),
        .level (level)
    );

    assign res_ready = !full_s;
    assign tx_data   = tx_data_r;
    assign tx_valid  = tx_valid_r;
    assign overflow  = overflow_r;
    assign xfer_s    = tx_valid_r && tx_ready;
    // A new frame loads from IDLE, or back-to-back as the previous LSB leaves.
    assign do_load_s = !empty_s && ((state_r == IDLE) || ((state_r == LSB) && xfer_s));

    // Next-state and next-byte selection for the serialiser.
    always_comb begin
        state_s    = state_r;
        hold_s     = hold_r;
        seq_s      = seq_r;
        tx_data_s  = tx_data_r;
        tx_valid_s = tx_valid_r;
        pop_s      = 1'b0;
        case (state_r)
            IDLE: begin
                tx_valid_s = 1'b0;
            end
            HDR: begin
                if (xfer_s) begin
                    state_s   = MSB;
                    tx_data_s = hold_r[15:8];
                end else begin
                    state_s = HDR;
                end
            end
            MSB: begin
                if (xfer_s) begin
                    state_s   = LSB;
                    tx_data_s = hold_r[7:0];
                end else begin
                    state_s = MSB;
                end
            end
            LSB: begin
                if (xfer_s) begin
                    seq_s      = seq_r + 4'd1;
                    state_s    = IDLE;
                    tx_valid_s = 1'b0;
                end else begin
                    state_s = LSB;
                end
            end
            default: begin
                state_s    = IDLE;
                tx_valid_s = 1'b0;
            end
        endcase
        // The header path is chosen here, so frame_en is effectively latched
        // into the state and later changes cannot reshape this frame.
        if (do_load_s) begin
            pop_s      = 1'b1;
            hold_s     = fifo_rdata_s;
            tx_valid_s = 1'b1;
            if (frame_en) begin
                state_s   = HDR;
                tx_data_s = dlf_header(fifo_rdata_s, seq_s);
            end else begin
                state_s   = MSB;
                tx_data_s = fifo_rdata_s[15:8];
            end
        end else begin
            pop_s = 1'b0;
        end
    end

    // Serialiser state and registered byte-stream outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            hold_r     <= 16'h0000;
            seq_r      <= 4'd0;
            tx_data_r  <= 8'h00;
            tx_valid_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            hold_r     <= hold_s;
            seq_r      <= seq_s;
            tx_data_r  <= tx_data_s;
            tx_valid_r <= tx_valid_s;
        end
    end

    // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r <= 1'b0;
        end else if (res_valid && full_s) begin
            overflow_r <= 1'b1;
        end else if (clr_ovf) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

endmodule
